// File: rtl/uni_shift_seq.sv
// Universal shift/rotate register with multi-cycle, programmable-distance shifts.
// One bit position moves per enabled cycle; start/busy/done handshake frames each command.
module uni_shift_seq #(
  parameter int N     = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [N-1:0]     d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             abort,
  output logic [N-1:0]     q,
  output logic             busy,
  output logic             done,
  output logic             sout_l,
  output logic             sout_r
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_r, op_n;
  logic [N-1:0]     q_n;
  logic             done_n;

  // One-position move; serial fills are taken live on every step.
  function automatic logic [N-1:0] step_q(input logic [2:0] o, input logic [N-1:0] v,
                                          input logic sl, input logic sr);
    case (o)
      OP_SLL:  step_q = {v[N-2:0], sr};
      OP_SRL:  step_q = {sl, v[N-1:1]};
      OP_SRA:  step_q = {v[N-1], v[N-1:1]};
      OP_ROL:  step_q = {v[N-2:0], v[N-1]};
      OP_ROR:  step_q = {v[0], v[N-1:1]};
      default: step_q = v;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_r;
    q_n     = q;
    done_n  = 1'b0;
    if (abort && state == RUN) begin
      // Cancel keeps the partial result and suppresses done.
      state_n = IDLE;
      cnt_n   = '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_HOLD: done_n = 1'b1;
              OP_LOAD: begin q_n = d;  done_n = 1'b1; end
              OP_CLR:  begin q_n = '0; done_n = 1'b1; end
              default: begin
                if (amt == '0) begin
                  done_n = 1'b1;
                end else begin
                  q_n = step_q(op, q, sin_l, sin_r);
                  if (amt == AMT_W'(1)) begin
                    done_n = 1'b1;
                  end else begin
                    state_n = RUN;
                    cnt_n   = amt - AMT_W'(1);
                    op_n    = op;
                  end
                end
              end
            endcase
          end
        end
        RUN: begin
          q_n   = step_q(op_r, q, sin_l, sin_r);
          cnt_n = cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= OP_HOLD;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_r  <= op_n;
      q     <= q_n;
      done  <= done_n;
    end
  end

  assign busy   = (state == RUN);
  assign sout_l = q[N-1];
  assign sout_r = q[0];

endmodule

// File: doc/uni_shift_seq.md
Name: uni_shift_seq

Overview:
- Parametrised successor to the team's universal shift register.
- N-bit register with registered output. Supports single-cycle hold, load and clear operations.
- Supports multi-cycle shifts and rotates by a programmable amount: one bit position per enabled cycle, with a start/busy/done handshake.
- Sits between datapath load logic and serial links/ALU stages that need variable-distance shifts without a barrel shifter.

Parameters:
N, 8, register width in bits (N >= 2)
AMT_W, 4, width of shift-amount input; max steps per command = 2^AMT_W - 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes register, counter and FSM (abort and reset still act)
start  input  1  command strobe, sampled at rising edge when en=1 and FSM in IDLE
op  input  3  000 hold, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110 load d, 111 clear
amt  input  AMT_W  number of 1-bit steps for op 001-101, latched on accepted start
d  input  N  parallel load data (op 110)
sin_l  input  1  serial fill bit entering MSB on SRL
sin_r  input  1  serial fill bit entering LSB on SLL
abort  input  1  synchronous cancel of a running command
q  output  N  registered contents
busy  output  1  1 while further steps of an accepted command remain
done  output  1  one-cycle pulse after final step of any accepted command
sout_l  output  1  equals q[N-1]
sout_r  output  1  equals q[0]

Behaviour:
- Reset (rst_n=0, asynchronous):
  - q=0, busy=0, done=0.
  - FSM to IDLE, step counter=0, latched op=000.
- FSM states: IDLE, RUN.
- IDLE, en=1, start=1 (accepted at edge t):
  - Ops 000/110/111: apply at edge t (q unchanged / q=d / q=0). After t: done=1, busy=0, stay IDLE.
  - Shift ops with amt=0: q unchanged. After t: done=1, busy=0.
  - Shift ops with amt=1: one step applied at edge t. After t: done=1, busy=0.
  - Shift ops with amt=k>1:
    - First step applied at edge t. Latch op; counter=k-1; enter RUN; busy=1.
    - In RUN, each enabled edge applies one step and decrements the counter.
    - At the edge where counter goes 1->0: apply the final step, return to IDLE. After that edge: busy=0, done=1.
    - Total: exactly k enabled edges; done visible after the k-th.
- Step definitions (one position per step):
  - SLL: q={q[N-2:0],sin_r}
  - SRL: q={sin_l,q[N-1:1]}
  - SRA: q={q[N-1],q[N-1:1]}
  - ROL: q={q[N-2:0],q[N-1]}
  - ROR: q={q[0],q[N-1:1]}
  - Serial inputs are sampled fresh on every step, not latched.
- amt > N is legal: steps continue. Rotates wrap (amt=N returns the original value). SRA saturates to all sign bits.
- done:
  - High for exactly one cycle, then 0, independent of en.
  - Never asserted without an accepted start.
- start while busy=1: ignored, no effect on op/counter/q.
- op/amt changes during RUN: ignored; the latched copies are used.
- en=0:
  - No step, no counter change, start not sampled, q held.
  - busy stays as is; a pending done still clears after one cycle.
  - RUN resumes when en returns to 1.
- abort=1 at an edge, in RUN (regardless of en):
  - Return to IDLE, busy=0, q keeps its current partial value, counter=0, no done pulse.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- Reset mid-RUN: immediate return to reset values; no done.
- sout_l/sout_r: combinational from registered q, so they change only at edges.

Test Plan:
- N=8. Reset, then load: rst_n=0 -> q=00, busy=0, done=0. Release; start, op=110, d=A5 -> after 1 edge q=A5, done=1 for one cycle, busy=0.
- Multi-step rotate: q=A5, start ROL amt=3 -> q=4B, 96, 2D on successive edges; busy=1,1,0; done=1 only after the third edge.
- SRA sign fill: q=90, start SRA amt=2 -> E4 after 2 edges. Same start with amt=9 -> FF, done after the 9th edge.
- Serial fill plus enable stall: q=00, SLL amt=4, sin_r=1, en=0 for 2 cycles after the second step -> q=01, 03, (held, held), 07, 0F; done after the 4th enabled edge; busy held during the stall.
- Abort and ignored start: ROR amt=5 on q=01; abort at the 2nd RUN edge with start=1 also asserted -> q=40 after that edge, busy=0, no done; next start accepted normally.
- Corner cases:
  - amt=0 SLL -> q unchanged, done pulse.
  - rst_n low mid-RUN -> q=00, busy=0 asynchronously.
